mem_bus_responder: RTL
======================

// Module: mem_bus_responder
// PURPOSE
//  Bus responder for the 6502 core. Answers every address/wr_data/wr_enable cycle
//  with zero-wait-state read data on rd_data. Contains RAM, a vector ROM overlay
//  and a memory-mapped byte I/O port with a TX FIFO and an RX holding register.
//  Sits between proc and the system top; I/O side drives a UART or bench consumer.
// PARAMETERS
//  RAM_AW     12        RAM address bits; RAM spans 0x0000..2^RAM_AW-1
//  IO_BASE    16'hD000  base of 3-byte I/O window (TX, STATUS, RX)
//  FIFO_AW    4         TX FIFO depth = 2^FIFO_AW entries
//  RESET_VEC  16'h0200  returned at 0xFFFC (LSB) / 0xFFFD (MSB)
//  NMI_VEC    16'h0000  returned at 0xFFFA / 0xFFFB
//  IRQ_VEC    16'h0000  returned at 0xFFFE / 0xFFFF
// PORTS
//  clk          in   1   single clock, rising edge
//  resetn       in   1   asynchronous, active-low reset
//  address      in   16  bus address from proc
//  wr_data      in   8   write data from proc
//  wr_enable    in   1   write strobe; each high cycle is one write
//  rd_data      out  8   read data, combinational from address and state
//  io_tx_data   out  8   FIFO head byte
//  io_tx_valid  out  1   FIFO non-empty
//  io_tx_ready  in   1   consumer accepts head when valid & ready
//  io_rx_data   in   8   incoming byte
//  io_rx_valid  in   1   incoming byte valid
//  io_rx_ready  out  1   RX holding register empty
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFO ptrs/level 0, overflow 0, rx_avail 0,
//    rx_hold 0x00. io_tx_valid 0, io_tx_data 0x00, io_rx_ready 1. RAM not reset.
//  - Map (decode priority top-down): 0xFFFA-0xFFFF vectors, LSB at even address
//    (writes ignored); IO_BASE+0 TX; IO_BASE+1 STATUS; IO_BASE+2 RX; RAM; other
//    addresses read 0xFF, writes ignored.
//  - Reads: no side effects; rd_data valid same cycle address is stable.
//  - Writes sampled on rising clk when wr_enable=1; RAM updated at that edge; read
//    of same address next cycle returns new data. Held wr_enable = repeated writes.
//  - TX write: push wr_data. STATUS write: wr_data[2]=1 clears overflow.
//    RX write (any data): clears rx_avail. TX/STATUS/RX writes never touch RAM.
//  - STATUS read: {4'b0, rx_avail, overflow, empty, full}; 0x02 after reset.
//  - TX FIFO: pop on io_tx_valid & io_tx_ready. Full with push+pop same edge:
//    both occur, level unchanged. Full with push only: byte dropped, overflow set
//    (sticky). Empty with push: io_tx_valid rises next cycle, no bypass.
//    io_tx_data = head entry when non-empty, 0x00 when empty. Pointers wrap mod
//    2^FIFO_AW; level is FIFO_AW+1 bits.
//  - RX: capture io_rx_data into rx_hold on io_rx_valid & io_rx_ready, set
//    rx_avail. io_rx_ready = !rx_avail. RX read returns rx_hold.
//    Clear with rx_avail=0 is a no-op.
//  - Overflow clear and drop in the same cycle: overflow remains set.
//  - Reset mid-operation: FIFO contents discarded immediately.
// CONFIGURATION
//  MEM_BUS_LOOPBACK_EN defined: io_rx_data/io_rx_valid ignored, io_tx_valid
//    forced 0. Each cycle FIFO non-empty and rx_avail=0, head pops into rx_hold
//    and rx_avail sets. io_rx_ready still = !rx_avail.
//  Undefined: external TX/RX handshakes as above.
// TESTING
//  1 reset, address=FFFC then FFFD -> rd_data 0x00 then 0x02; STATUS reads 0x02
//  2 write 0x0010<=0xA5, next cycle read 0x0010 -> 0xA5; read 0x1000 -> 0xFF
//  3 io_tx_ready=0, write D000 with 0..16 over 17 cycles -> STATUS=0x05;
//    ready=1 -> bytes 0..15 drained in order, 16 never seen, then STATUS=0x06
//  4 FIFO full, TX write 0xEE with io_tx_ready=1 same cycle -> accepted,
//    full stays 1, overflow stays 0, 0xEE drained last
//  5 io_rx_valid=1 data 0x3C -> io_rx_ready=0, STATUS bit3=1, D002 reads 0x3C;
//    write D002 -> io_rx_ready=1 next cycle
//  6 MEM_BUS_LOOPBACK_EN, write D000<=0x55 -> within 2 cycles D002 reads 0x55,
//    STATUS bit3=1, io_tx_valid never high

Source files
------------

// File: rtl/mem_bus_responder.sv
// 6502 bus responder: RAM, vector ROM, TX FIFO/RX byte port. Zero-wait reads, TX drops on full without pop.
// Optional MEM_BUS_LOOPBACK_EN routes the TX FIFO head straight into the RX holding register.
module mem_bus_responder #(
  parameter int          RAM_AW    = 12,
  parameter logic [15:0] IO_BASE   = 16'hD000,
  parameter int          FIFO_AW   = 4,
  parameter logic [15:0] RESET_VEC = 16'h0200,
  parameter logic [15:0] NMI_VEC   = 16'h0000,
  parameter logic [15:0] IRQ_VEC   = 16'h0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  wr_data,
  input  logic        wr_enable,
  output logic [7:0]  rd_data,
  output logic [7:0]  io_tx_data,
  output logic        io_tx_valid,
  input  logic        io_tx_ready,
  input  logic [7:0]  io_rx_data,
  input  logic        io_rx_valid,
  output logic        io_rx_ready
);

  localparam int RAM_DEPTH  = 2**RAM_AW;
  localparam int FIFO_DEPTH = 2**FIFO_AW;

  logic [7:0]         ram      [RAM_DEPTH];
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   level;
  logic               overflow;
  logic               rx_avail;
  logic [7:0]         rx_hold;

  logic vec_sel, tx_sel, status_sel, rx_sel, ram_sel;
  logic fifo_empty, fifo_full;
  logic tx_push, pop, push_ok, drop;
  logic rx_cap, rx_clr, ovf_clr;
  logic [7:0] head, rx_in;

  assign vec_sel    = address >= 16'hFFFA;
  assign tx_sel     = !vec_sel && (address == IO_BASE);
  assign status_sel = !vec_sel && (address == IO_BASE + 16'd1);
  assign rx_sel     = !vec_sel && (address == IO_BASE + 16'd2);
  assign ram_sel    = !vec_sel && !tx_sel && !status_sel && !rx_sel &&
                      ({1'b0, address} < 17'(RAM_DEPTH));

  assign fifo_empty = (level == '0);
  // Level never exceeds the depth, so its MSB alone marks full.
  assign fifo_full  = level[FIFO_AW];
  assign head       = fifo_mem[rd_ptr];

  assign tx_push = wr_enable && tx_sel;
  assign push_ok = tx_push && (!fifo_full || pop);
  assign drop    = tx_push && fifo_full && !pop;
  assign rx_clr  = wr_enable && rx_sel;
  assign ovf_clr = wr_enable && status_sel && wr_data[2];

`ifdef MEM_BUS_LOOPBACK_EN
  logic unused_loopback;
  assign unused_loopback = ^{io_tx_ready, io_rx_valid, io_rx_data};
  assign pop         = !fifo_empty && !rx_avail;
  assign rx_cap      = pop;
  assign rx_in       = head;
  assign io_tx_valid = 1'b0;
`else
  assign pop         = !fifo_empty && io_tx_ready;
  assign rx_cap      = io_rx_valid && !rx_avail;
  assign rx_in       = io_rx_data;
  assign io_tx_valid = !fifo_empty;
`endif

  assign io_tx_data  = fifo_empty ? 8'h00 : head;
  assign io_rx_ready = !rx_avail;

  // TX register is write-only and reads back as zero.
  always_comb begin
    rd_data = 8'hFF;
    if (vec_sel) begin
      case (address[2:0])
        3'b010:  rd_data = NMI_VEC[7:0];
        3'b011:  rd_data = NMI_VEC[15:8];
        3'b100:  rd_data = RESET_VEC[7:0];
        3'b101:  rd_data = RESET_VEC[15:8];
        3'b110:  rd_data = IRQ_VEC[7:0];
        3'b111:  rd_data = IRQ_VEC[15:8];
        default: rd_data = 8'hFF;
      endcase
    end else if (tx_sel) begin
      rd_data = 8'h00;
    end else if (status_sel) begin
      rd_data = {4'b0000, rx_avail, overflow, fifo_empty, fifo_full};
    end else if (rx_sel) begin
      rd_data = rx_hold;
    end else if (ram_sel) begin
      rd_data = ram[address[RAM_AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_enable && ram_sel) ram[address[RAM_AW-1:0]] <= wr_data;
    if (push_ok) fifo_mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      rx_avail <= 1'b0;
      rx_hold  <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (FIFO_AW+1)'(1);
        2'b01:   level <= level - (FIFO_AW+1)'(1);
        default: level <= level;
      endcase
      // A drop in the same cycle as a clear leaves overflow set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
      if (rx_cap) begin
        rx_hold  <= rx_in;
        rx_avail <= 1'b1;
      end else if (rx_clr) begin
        rx_avail <= 1'b0;
      end
    end
  end

endmodule
